// File: rtl/pcie_tl_pkg.sv
// Shared transaction-layer definitions: word geometry, VC index type and the
// two-state scheduler encoding used by the egress arbiter.
package pcie_tl_pkg;

    localparam int LINE_SIZE = 12;
    localparam int NUM_VC    = 4;

    typedef logic [1:0] vc_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational four-way round-robin picker: returns the first requester found
// searching upward from last+1, wrapping, so that 'last' itself ranks lowest.
module rr_pick4
    import pcie_tl_pkg::*;
(
    input  logic [3:0] request,
    input  vc_idx_t    last,
    output vc_idx_t    grant,
    output logic       valid
);

    vc_idx_t cand;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 4; k >= 1; k--) begin
            cand = last + vc_idx_t'(k);
            if (request[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_egress_arbiter.sv
// Merges the four virtual-channel FIFOs into one egress FIFO: round-robin grants
// with a bounded burst, one-cycle pop-to-push latency, almost_full back-pressure.
module vc_egress_arbiter
    import pcie_tl_pkg::*;
#(
    parameter int LINE_SIZE = pcie_tl_pkg::LINE_SIZE,
    parameter int NUM_VC    = pcie_tl_pkg::NUM_VC,
    parameter int BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_VC-1:0]           vc_empty,
    input  logic [NUM_VC*LINE_SIZE-1:0] vc_data,
    input  logic                        almost_full_signal,
    output logic [NUM_VC-1:0]           pop_signal,
    output logic                        push_signal,
    output logic [LINE_SIZE-1:0]        data_out,
    output vc_idx_t                     active_vc,
    output logic                        idle
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    arb_state_t           state_reg, state_next;
    vc_idx_t              last_grant_reg, last_grant_next;
    vc_idx_t              active_vc_reg, active_vc_next;
    logic [3:0]           burst_cnt_reg, burst_cnt_next;
    logic                 push_reg;
    logic [LINE_SIZE-1:0] data_out_reg;
    logic                 pop_any;
    vc_idx_t              pick_grant;
    logic                 pick_valid;
    logic [LINE_SIZE-1:0] vc_word [NUM_VC];

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_unpack
            assign vc_word[gi] = vc_data[gi*LINE_SIZE +: LINE_SIZE];
        end
    endgenerate

    rr_pick4 u_pick (
        .request (~vc_empty),
        .last    (last_grant_reg),
        .grant   (pick_grant),
        .valid   (pick_valid)
    );

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        active_vc_next  = active_vc_reg;
        burst_cnt_next  = burst_cnt_reg;
        pop_any         = 1'b0;
        pop_signal      = '0;
        case (state_reg)
            IDLE: begin
                if (pick_valid && !almost_full_signal) begin
                    active_vc_next = pick_grant;
                    burst_cnt_next = '0;
                    state_next     = SERVE;
                end
            end
            SERVE: begin
                pop_any = !vc_empty[active_vc_reg] && !almost_full_signal
                          && (burst_cnt_reg < BURST_LIM);
                if (pop_any) begin
                    burst_cnt_next = burst_cnt_reg + 4'd1;
                end else begin
                    // Drained, stalled or bursted-out: this VC drops to lowest priority.
                    state_next      = IDLE;
                    last_grant_next = active_vc_reg;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            pop_any = 1'b0;
        end
        pop_signal[active_vc_reg] = pop_any;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 2'd3;
            active_vc_reg  <= '0;
            burst_cnt_reg  <= '0;
            push_reg       <= 1'b0;
            data_out_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            active_vc_reg  <= active_vc_next;
            burst_cnt_reg  <= burst_cnt_next;
            push_reg       <= pop_any;
            if (pop_any) begin
                data_out_reg <= vc_word[active_vc_reg];
            end
        end
    end

    assign push_signal = push_reg;
    assign data_out    = data_out_reg;
    assign active_vc   = active_vc_reg;
    assign idle        = (state_reg == IDLE) && !push_reg;

endmodule

// File: tb/tb_vc_egress_arbiter.sv
// Scoreboard bench for vc_egress_arbiter: FIFO models feed the DUT, a
// transaction-level scheduler model predicts the egress word order.
module tb_vc_egress_arbiter;

    localparam int LS = 12;
    localparam int NV = 4;
    localparam int BM = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NV-1:0]  vc_empty = '1;
    logic [NV*LS-1:0] vc_data = '0;
    logic           af = 1'b0;
    logic [NV-1:0]  pop_signal;
    logic           push_signal;
    logic [LS-1:0]  data_out;
    logic [1:0]     active_vc;
    logic           idle;

    vc_egress_arbiter #(.LINE_SIZE(LS), .NUM_VC(NV), .BURST_MAX(BM)) dut (
        .clk                (clk),
        .reset              (reset),
        .vc_empty           (vc_empty),
        .vc_data            (vc_data),
        .almost_full_signal (af),
        .pop_signal         (pop_signal),
        .push_signal        (push_signal),
        .data_out           (data_out),
        .active_vc          (active_vc),
        .idle               (idle)
    );

    always #5 clk = ~clk;

    logic [LS-1:0] fifo   [NV][$];
    logic [LS-1:0] mq     [NV][$];
    logic [LS-1:0] exp_q  [$];
    logic [LS-1:0] exp_vc [NV][$];
    int n_cmp = 0, n_fail = 0, n_push = 0;
    int model_grants = 0;
    int seen_pop = 0, idle_run = 0, idle_gaps = 0;
    bit chk_en = 1'b0, tag_mode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // VC FIFO models: registered empty flag, show-ahead head word.
    always @(posedge clk) begin
        for (int i = 0; i < NV; i++) begin
            if (pop_signal[i] === 1'b1) begin
                n_cmp++;
                if (fifo[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_of_empty: vc %0d got pop, required no pop", i);
                end else begin
                    void'(fifo[i].pop_front());
                end
            end
        end
        for (int i = 0; i < NV; i++) begin
            vc_empty[i] <= (fifo[i].size() == 0);
            vc_data[i*LS +: LS] <= (fifo[i].size() > 0) ? fifo[i][0] : '0;
        end
    end

    // Monitor: scoreboard pop on each push, legality of pops, idle gaps between grants.
    always @(posedge clk) begin
        logic [LS-1:0] e;
        int tag;
        #1;
        if (push_signal) begin
            n_push++;
            $display("push %0d: data_out=0x%03h active_vc=%0d", n_push, data_out, active_vc);
            if (chk_en) begin
                n_cmp++;
                tag = int'(data_out[LS-1:LS-2]);
                if (tag_mode ? (exp_vc[tag].size() == 0) : (exp_q.size() == 0)) begin
                    n_fail++;
                    $display("FAIL unexpected_push: got 0x%03h, required no push", data_out);
                end else begin
                    e = tag_mode ? exp_vc[tag].pop_front() : exp_q.pop_front();
                    if (data_out !== e) begin
                        n_fail++;
                        $display("FAIL push_data: got 0x%03h, required 0x%03h", data_out, e);
                    end
                end
            end
        end
        if (|pop_signal) begin
            n_cmp++;
            if (!$onehot(pop_signal) || af) begin
                n_fail++;
                $display("FAIL pop_legal: got pop=%b af=%b, required one-hot pop with af=0", pop_signal, af);
            end
            if (seen_pop != 0) idle_gaps += idle_run;
            seen_pop = 1;
            idle_run = 0;
        end else if (idle && seen_pop != 0) begin
            idle_run++;
        end
    end

    // Reference scheduler: whole grants at a time from the queued contents.
    function automatic void build_expect(input int last_in, input int cut_first);
        int last = last_in;
        int v, n;
        bit first = 1'b1;
        model_grants = 0;
        while (1) begin
            v = -1;
            for (int k = 1; k <= NV; k++)
                if (v < 0 && mq[(last + k) % NV].size() > 0) v = (last + k) % NV;
            if (v < 0) break;
            n = (mq[v].size() > BM) ? BM : mq[v].size();
            if (first && cut_first > 0 && n > cut_first) n = cut_first;
            first = 1'b0;
            for (int j = 0; j < n; j++) exp_q.push_back(mq[v].pop_front());
            model_grants++;
            last = v;
        end
    endfunction

    task automatic prepare(input int last, input int cut);
        for (int i = 0; i < NV; i++) mq[i] = fifo[i];
        build_expect(last, cut);
        seen_pop = 0; idle_run = 0; idle_gaps = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; chk_en = 1'b0; tag_mode = 1'b0; af = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NV; i++) begin
            fifo[i].delete();
            exp_vc[i].delete();
        end
        @(negedge clk);
    endtask

    task automatic release_reset(input bit chk);
        chk_en = chk;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic fill(input int vc, input int n);
        for (int j = 0; j < n; j++) fifo[vc].push_back(LS'($urandom_range(0, 4095)));
    endtask

    task automatic wait_drain(input string name, input bit rand_af);
        int cyc = 0;
        bit done = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (rand_af) af = ($urandom_range(0, 99) < 35);
            done = idle && exp_q.size() == 0;
            for (int i = 0; i < NV; i++)
                if (fifo[i].size() != 0 || exp_vc[i].size() != 0) done = 1'b0;
        end
        af = 1'b0;
        n_cmp++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: got timeout after %0d cycles, required full drain", name, cyc);
        end
    endtask

    task automatic first_pop_check(input string name, input logic [3:0] req);
        int cyc = 0;
        while (pop_signal == 4'b0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 32'(pop_signal), 32'(req));
    endtask

    initial begin
        int pb, pops, cyc;

        // Reset values while all VCs hold data, then full round-robin drain.
        do_reset();
        for (int v = 0; v < NV; v++) fill(v, 6);
        prepare(3, 0);
        repeat (2) begin
            @(negedge clk);
            check("rst_vc_empty", 32'(vc_empty), 0);
            check("rst_pop", 32'(pop_signal), 0);
            check("rst_push", 32'(push_signal), 0);
            check("rst_data", 32'(data_out), 0);
            check("rst_idle", 32'(idle), 1);
            check("rst_active_vc", 32'(active_vc), 0);
        end
        pb = n_push;
        release_reset(1);
        wait_drain("rr_burst", 0);
        check("rr_push_total", n_push - pb, 24);
        check("rr_idle_gaps", idle_gaps, model_grants - 1);

        // Single VC with fixed words.
        do_reset();
        fifo[2].push_back(12'hDE4); fifo[2].push_back(12'h96C); fifo[2].push_back(12'h123);
        prepare(3, 0);
        pb = n_push;
        release_reset(1);
        first_pop_check("single_first_pop", 4'b0100);
        wait_drain("single", 0);
        check("single_push_total", n_push - pb, 3);
        check("single_idle", 32'(idle), 1);

        // Back-pressure in the middle of a VC1 burst.
        do_reset();
        fill(1, 6); fill(2, 3);
        prepare(3, 2);
        release_reset(1);
        pops = 0; cyc = 0;
        while (pops < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (pop_signal[1]) pops++;
        end
        check("bp_vc1_pops", pops, 2);
        @(negedge clk);
        af = 1'b1;
        #1;
        check("bp_pop_same_cycle", 32'(pop_signal), 0);
        pb = n_push;
        repeat (6) @(negedge clk);
        check("bp_inflight_le1", 32'(n_push - pb <= 1), 1);
        check("bp_idle", 32'(idle), 1);
        af = 1'b0;
        first_pop_check("bp_next_vc2", 4'b0100);
        wait_drain("bp", 0);

        // Empty VCs skipped: VC0 served first so last_grant=0, then VC0 and VC3 loaded.
        do_reset();
        fill(0, 1);
        prepare(3, 0);
        release_reset(1);
        wait_drain("skip_pre", 0);
        @(negedge clk);
        fill(0, 3); fill(3, 2);
        prepare(0, 0);
        first_pop_check("skip_first_vc3", 4'b1000);
        wait_drain("skip", 0);
        check("skip_idle_gaps", idle_gaps, 1);

        // Reset in the middle of a VC0 burst.
        do_reset();
        fill(0, 6); fill(1, 2);
        release_reset(0);
        cyc = 0;
        while (!pop_signal[0] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_pop_forced", 32'(pop_signal), 0);
        @(negedge clk);
        check("midrst_push", 32'(push_signal), 0);
        check("midrst_idle", 32'(idle), 1);
        prepare(3, 0);
        release_reset(1);
        first_pop_check("midrst_restart_vc0", 4'b0001);
        wait_drain("midrst", 0);

        // Random fills, no back-pressure: exact order and bubble count from the model.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int v = 0; v < NV; v++) fill(v, $urandom_range(0, 9));
            prepare(3, 0);
            release_reset(1);
            wait_drain("rand", 0);
            if (model_grants > 0) check("rand_idle_gaps", idle_gaps, model_grants - 1);
        end

        // Random back-pressure: per-VC order and completeness via tagged words.
        for (int it = 0; it < 3; it++) begin
            do_reset();
            tag_mode = 1'b1;
            for (int v = 0; v < NV; v++) begin
                int n = $urandom_range(0, 12);
                for (int j = 0; j < n; j++) begin
                    logic [LS-1:0] w;
                    w = {2'(v), 10'(j + it * 64)};
                    fifo[v].push_back(w);
                    exp_vc[v].push_back(w);
                end
            end
            release_reset(1);
            wait_drain("soak", 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
